// File: rtl/adder_op_sequencer_pkg.sv
// Shared types and constants for the adder op sequencer.
package adder_op_sequencer_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;
endpackage

// File: rtl/adder_op_sequencer_settle_timer.sv
// Settle-window down-counter: loads on accept, counts to zero, flags the capture cycle.
import adder_op_sequencer_pkg::*;

module adder_op_sequencer_settle_timer (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  // Load on accept; otherwise decrement until zero and park there.
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  // The edge on which cnt==1 is the last cycle of the settle window.
  assign done = (cnt == CNT_W'(1));
endmodule

// File: rtl/adder_op_sequencer.sv
// Clocked front/back stage around an external ripple add/sub datapath:
// holds operands stable for SETTLE_CYCLES, then captures sum and flags.
import adder_op_sequencer_pkg::*;

module adder_op_sequencer #(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("adder_op_sequencer: SETTLE_CYCLES must be in 1..255");
    end
  endgenerate

  state_t state, state_nxt;
  logic   accept, capture, done;

  assign accept  = in_valid & in_ready;
  assign capture = (state == S_SETTLE) & done;

  adder_op_sequencer_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .done     (done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake decode; in_ready never looks at in_valid.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (done) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? S_SETTLE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Adder operands change only on an accept edge, so they are stable while settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_x   <= '0;
      add_y   <= '0;
      add_cin <= 1'b0;
    end else if (accept) begin
      add_x   <= in_a;
      add_y   <= in_b;
      add_cin <= in_sub;
    end
  end

  // Capture sum and derive flags at the end of the settle window; held through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum <= '0;
      out_v   <= 1'b0;
      out_z   <= 1'b0;
      out_n   <= 1'b0;
    end else if (capture) begin
      out_sum <= add_s;
      out_v   <= add_v;
      out_z   <= (add_s == '0);
      out_n   <= add_s[WIDTH-1];
    end
  end
endmodule
